c_tile_reader_flat: RTL and testbench

Read-side counterpart of the C-tile write path in the EPU MAC. Once a C tile has been written into `sram_mem_mn_c` and the tile is declared complete, this block sweeps all M×N words out through SRAM port A in row-major order. It emits them as a valid/ready element stream for the downstream consumer (EPU post-processing or DMA). Optionally it also reassembles them into a flat `M*N*DATA_W` vector mirroring the systolic-array output format.

---
 rtl/c_tile_pkg.sv | 21 ++
 rtl/c_tile_addr_seq.sv | 53 +++++
 rtl/c_tile_reader_flat.sv | 169 ++++++++++++++++
 tb/tb_c_tile_reader_flat.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/c_tile_pkg.sv
// rtl/c_tile_pkg.sv - shared types and index helpers for the C-tile reader
package c_tile_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    REQ,
    OUT,
    DONE
  } rd_state_t;

  // Index width for a dimension; a single-entry dimension still gets one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int flat_idx(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/c_tile_addr_seq.sv
// rtl/c_tile_addr_seq.sv - row-major row/col counter for the C-tile sweep
module c_tile_addr_seq #(
  parameter int M     = 8,
  parameter int N     = 8,
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(M - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(N - 1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/c_tile_reader_flat.sv
// rtl/c_tile_reader_flat.sv - sweeps a C tile out of SRAM port A as a row-major element stream
// Flat tile reassembly (c_flat_o / c_flat_valid_o) is present only when C_RD_FLAT_EN is defined.
module c_tile_reader_flat
  import c_tile_pkg::*;
#(
  parameter int M      = 8,
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int ROW_W  = idx_w(M),
  parameter int COL_W  = idx_w(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              tile_ready,
  output logic              busy,
  output logic              done,
  output logic              c_en,
  output logic              c_re,
  output logic [ROW_W-1:0]  c_row,
  output logic [COL_W-1:0]  c_col,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic              c_rvalid,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [DATA_W-1:0] s_data,
  output logic [ROW_W-1:0]  s_row,
  output logic [COL_W-1:0]  s_col,
  output logic              s_last
`ifdef C_RD_FLAT_EN
  ,
  output logic [M*N*DATA_W-1:0] c_flat_o,
  output logic [M*N-1:0]        c_flat_valid_o
`endif
);

  rd_state_t state_q, state_d;

  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [ROW_W-1:0]  s_row_q, s_row_d;
  logic [COL_W-1:0]  s_col_q, s_col_d;
  logic              s_last_q, s_last_d;

  logic             seq_clear, seq_advance, seq_last, capture;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  c_tile_addr_seq #(
    .M    (M),
    .N    (N),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_addr_seq (
    .clk    (clk),
    .rst    (rst),
    .clear  (seq_clear),
    .advance(seq_advance),
    .row    (row),
    .col    (col),
    .last   (seq_last)
  );

  always_comb begin
    state_d     = state_q;
    seq_clear   = 1'b0;
    seq_advance = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d   = ARM;
        seq_clear = 1'b1;
      end
      ARM: if (tile_ready) state_d = REQ;
      REQ: if (c_rvalid) begin
        state_d = OUT;
        capture = 1'b1;
      end
      OUT: if (s_ready) begin
        if (s_last_q) begin
          state_d = DONE;
        end else begin
          state_d     = REQ;
          seq_advance = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_data_d = s_data_q;
    s_row_d  = s_row_q;
    s_col_d  = s_col_q;
    s_last_d = s_last_q;
    if (capture) begin
      s_data_d = c_rdata;
      s_row_d  = row;
      s_col_d  = col;
      s_last_d = seq_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      s_data_q <= '0;
      s_row_q  <= '0;
      s_col_q  <= '0;
      s_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_data_q <= s_data_d;
      s_row_q  <= s_row_d;
      s_col_q  <= s_col_d;
      s_last_q <= s_last_d;
    end
  end

  // Port A is quiet outside REQ so the SRAM sees only one request at a time.
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign c_en    = (state_q == REQ);
  assign c_re    = c_en;
  assign c_row   = c_en ? row : '0;
  assign c_col   = c_en ? col : '0;
  assign s_valid = (state_q == OUT);
  assign s_data  = s_data_q;
  assign s_row   = s_row_q;
  assign s_col   = s_col_q;
  assign s_last  = s_valid & s_last_q;

`ifdef C_RD_FLAT_EN
  localparam int SLOT_W = idx_w(M * N);

  logic [DATA_W-1:0] flat_q [M*N];
  logic [DATA_W-1:0] flat_d [M*N];
  logic [M*N-1:0]    flat_valid_q, flat_valid_d;
  logic [SLOT_W-1:0] slot;

  assign slot = SLOT_W'(flat_idx(int'(row), int'(col), N));

  always_comb begin
    flat_d       = flat_q;
    flat_valid_d = flat_valid_q;
    if (seq_clear) flat_valid_d = '0;
    if (capture) begin
      flat_d[slot]       = c_rdata;
      flat_valid_d[slot] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < M * N; k++) flat_q[k] <= '0;
      flat_valid_q <= '0;
    end else begin
      flat_q       <= flat_d;
      flat_valid_q <= flat_valid_d;
    end
  end

  for (genvar k = 0; k < M * N; k++) begin : g_flat_pack
    assign c_flat_o[k*DATA_W +: DATA_W] = flat_q[k];
  end
  assign c_flat_valid_o = flat_valid_q;
`endif

endmodule

// File: tb/tb_c_tile_reader_flat.sv
// tb/tb_c_tile_reader_flat.sv - directed self-checking bench for c_tile_reader_flat (2x2 and 8x8 instances)
module tb_c_tile_reader_flat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tile_ready, s_ready, start2, start8;
  int   lat;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        busy2, done2, c_en2, c_re2, c_rvalid2, s_valid2, s_last2;
  logic [0:0]  c_row2, c_col2, s_row2, s_col2;
  logic [31:0] c_rdata2, s_data2;

  logic        busy8, done8, c_en8, c_re8, c_rvalid8, s_valid8, s_last8;
  logic [2:0]  c_row8, c_col8, s_row8, s_col8;
  logic [31:0] c_rdata8, s_data8;
`ifdef C_RD_FLAT_EN
  logic [127:0]  c_flat2;
  logic [3:0]    c_flat_valid2;
  logic [2047:0] c_flat8;
  logic [63:0]   c_flat_valid8;
`endif

  c_tile_reader_flat #(.M(2), .N(2), .DATA_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .tile_ready(tile_ready),
    .busy(busy2), .done(done2), .c_en(c_en2), .c_re(c_re2),
    .c_row(c_row2), .c_col(c_col2), .c_rdata(c_rdata2), .c_rvalid(c_rvalid2),
    .s_valid(s_valid2), .s_ready(s_ready), .s_data(s_data2),
    .s_row(s_row2), .s_col(s_col2), .s_last(s_last2)
`ifdef C_RD_FLAT_EN
    , .c_flat_o(c_flat2), .c_flat_valid_o(c_flat_valid2)
`endif
  );

  c_tile_reader_flat #(.M(8), .N(8), .DATA_W(32)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .tile_ready(tile_ready),
    .busy(busy8), .done(done8), .c_en(c_en8), .c_re(c_re8),
    .c_row(c_row8), .c_col(c_col8), .c_rdata(c_rdata8), .c_rvalid(c_rvalid8),
    .s_valid(s_valid8), .s_ready(s_ready), .s_data(s_data8),
    .s_row(s_row8), .s_col(s_col8), .s_last(s_last8)
`ifdef C_RD_FLAT_EN
    , .c_flat_o(c_flat8), .c_flat_valid_o(c_flat_valid8)
`endif
  );

  // SRAM models: rvalid arrives in the lat-th consecutive request cycle.
  int cnt2, cnt8;
  always @(posedge clk) begin
    cnt2 <= c_en2 ? cnt2 + 1 : 0;
    cnt8 <= c_en8 ? cnt8 + 1 : 0;
  end
  assign c_rvalid2 = c_en2 && (cnt2 == lat - 1);
  assign c_rvalid8 = c_en8 && (cnt8 == lat - 1);
  assign c_rdata2  = ((32'(c_row2) + 32'd1) << 4) | 32'(c_col2);
  assign c_rdata8  = 32'hC000_0000 | (32'(c_row8) << 8) | 32'(c_col8);

  localparam logic [31:0] T1_EXP [4] = '{32'h10, 32'h11, 32'h20, 32'h21};

  logic [31:0] el_data [64];
  int          el_row  [64];
  int          el_col  [64];
  logic        el_last [64];
  int el_n, done_cyc, run_len, run_cnt, run_bad, stall_bad, stall_cen, dn, errs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int order_errs8();
    int e = 0;
    for (int k = 0; k < 64; k++) begin
      if (el_data[k] !== (32'hC000_0000 | 32'((k / 8) << 8) | 32'(k % 8))) e++;
      if (el_row[k] != k / 8 || el_col[k] != k % 8) e++;
      if (el_last[k] !== (k == 63)) e++;
    end
    return e;
  endfunction

  // Full 8x8 sweep from IDLE; cycle 0 is the first REQ cycle.
  task automatic sweep8(input int stall_elem, input int abort_elem);
    int          stall = 0;
    logic [5:0]  prev_addr = '0;
    logic [31:0] hold_data = '0;
    logic [5:0]  hold_rc = '0;
    el_n = 0; done_cyc = -1; run_len = 0; run_cnt = 0; run_bad = 0;
    stall_bad = 0; stall_cen = 0;
    s_ready = 1'b1;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (c_en8) begin
        if (run_len > 0 && {c_row8, c_col8} != prev_addr) run_bad++;
        prev_addr = {c_row8, c_col8};
        run_len++;
      end else if (run_len > 0) begin
        run_cnt++;
        if (run_len != lat) run_bad++;
        run_len = 0;
      end
      if (done8) begin
        done_cyc = cyc;
        step();
        return;
      end
      if (s_valid8) begin
        if (el_n == abort_elem) return;
        if (el_n == stall_elem && stall < 3) begin
          if (stall == 0) begin
            hold_data = s_data8;
            hold_rc   = {s_row8, s_col8};
          end else if (s_data8 !== hold_data || {s_row8, s_col8} !== hold_rc) begin
            stall_bad++;
          end
          if (c_en8) stall_cen++;
          stall++;
          s_ready = 1'b0;
        end else begin
          s_ready = 1'b1;
          el_data[el_n] = s_data8;
          el_row[el_n]  = int'(s_row8);
          el_col[el_n]  = int'(s_col8);
          el_last[el_n] = s_last8;
          el_n++;
        end
      end
      step();
    end
    s_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start2 = 1'b0; start8 = 1'b0; tile_ready = 1'b1; s_ready = 1'b1; lat = 1;
    step();
    step();
    check("rst_busy",   64'(busy8), 0);
    check("rst_done",   64'(done8), 0);
    check("rst_port_a", 64'({c_en8, c_re8, c_row8, c_col8}), 0);
    check("rst_stream", 64'({s_valid8, s_last8, s_row8, s_col8}), 0);
    check("rst_s_data", 64'(s_data8), 0);
`ifdef C_RD_FLAT_EN
    check("rst_flat_valid", 64'(c_flat_valid8), 0);
`endif
    rst = 1'b0;
    step();

    // 2x2, L=1, s_ready high
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    check("t1_arm_busy", 64'(busy2), 1);
    check("t1_arm_no_en", 64'(c_en2), 0);
    step();
    check("t1_req_en", 64'({c_en2, c_re2}), 3);
    el_n = 0; done_cyc = -1; dn = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (s_valid2) begin
        if (el_n < 4) begin
          el_data[el_n] = s_data2;
          el_row[el_n]  = int'(s_row2);
          el_col[el_n]  = int'(s_col2);
          el_last[el_n] = s_last2;
        end
        el_n++;
      end
      if (done2) begin
        if (done_cyc < 0) done_cyc = cyc;
        dn++;
      end
      step();
    end
    check("t1_count", 64'(el_n), 4);
    check("t1_done_cycle", 64'(done_cyc), 8);
    check("t1_done_pulses", 64'(dn), 1);
    for (int k = 0; k < 4; k++) begin
      check("t1_data", 64'(el_data[k]), 64'(T1_EXP[k]));
      check("t1_row_col_last", 64'({el_row[k][1:0], el_col[k][1:0], el_last[k]}),
            64'({2'(k / 2), 2'(k % 2), (k == 3)}));
    end
    check("t1_idle", 64'(busy2), 0);

    // tile_ready gating on 8x8
    tile_ready = 1'b0;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (c_en8) dn++;
      step();
    end
    check("t2_no_c_en", 64'(dn), 0);
    check("t2_busy_arm", 64'(busy8), 1);
    tile_ready = 1'b1;
    step();
    check("t2_req_after_ready", 64'({c_en8, c_row8, c_col8}), 64'(7'b1000000));
    rst = 1'b1;
    step();
    rst = 1'b0;

    // stall three cycles on the second element
    sweep8(1, -1);
    check("t3_done_cycle", 64'(done_cyc), 131);
    check("t3_count", 64'(el_n), 64);
    check("t3_stall_stable", 64'(stall_bad), 0);
    check("t3_stall_no_c_en", 64'(stall_cen), 0);
    check("t3_elem1", 64'(el_data[1]), 64'h0000_0000_C000_0001);
    check("t3_order", 64'(order_errs8()), 0);

    // read latency 3
    lat = 3;
    sweep8(-1, -1);
    check("t4_done_cycle", 64'(done_cyc), 256);
    check("t4_req_runs", 64'(run_cnt), 64);
    check("t4_req_hold", 64'(run_bad), 0);
    check("t4_order", 64'(order_errs8()), 0);
    lat = 1;

    // reset while element 10 is presented
    sweep8(-1, 9);
    check("t5_at_elem10", 64'({s_valid8, s_row8, s_col8}), 64'(7'b1001001));
    rst = 1'b1;
    step();
    check("t5_rst_ctrl", 64'({busy8, done8, c_en8, c_re8, s_valid8, s_last8}), 0);
    check("t5_rst_addr", 64'({c_row8, c_col8, s_row8, s_col8}), 0);
    check("t5_rst_data", 64'(s_data8), 0);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (done8 || busy8) dn++;
      step();
    end
    check("t5_no_done_after_rst", 64'(dn), 0);
    sweep8(-1, -1);
    check("t5_restart_first", 64'({el_data[0], 8'(el_row[0]), 8'(el_col[0])}), 64'h0000_C000_0000_0000);
    check("t5_restart_done", 64'(done_cyc), 128);
    check("t5_restart_order", 64'(order_errs8()), 0);

`ifdef C_RD_FLAT_EN
    errs = 0;
    for (int k = 0; k < 64; k++)
      if (c_flat8[k*32 +: 32] !== (32'hC000_0000 | 32'((k / 8) << 8) | 32'(k % 8))) errs++;
    check("t6_flat_slots", 64'(errs), 0);
    check("t6_flat_valid", 64'(c_flat_valid8), 64'hFFFF_FFFF_FFFF_FFFF);
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    check("t6_flat_valid_clear", 64'(c_flat_valid8), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
